// File: rtl/instr_prefetch_buffer_if.sv
// Bundle of imem request/response, redirect and decode-side handshake signals
// for the instruction prefetch buffer.
interface instr_prefetch_buffer_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic [6:0]      op;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, op,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, op,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// In-order instruction prefetch buffer: credit-throttled imem fetch, DEPTH-entry
// queue toward decode, flush with stale-response dropping on redirect.
module instr_prefetch_buffer #(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                   clk,
  input logic                   reset,
  instr_prefetch_buffer_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } entry_t;

  entry_t          entries_q [DEPTH];
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic            req_valid_q, instr_valid_q;
  logic            req_fire, out_fire, rsp_ok, wr_en, credit_ok;

  // Next-state: redirect flushes everything and converts in-flight requests to drops
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    wr_en      = 1'b0;

    req_fire = req_valid_q & bus.imem_req_ready;
    out_fire = instr_valid_q & bus.instr_ready;
    // A response with nothing in flight is a protocol error and is ignored
    rsp_ok   = bus.imem_rsp_valid & ((outst_q != '0) | (drop_q != '0));

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
      rsp_pc_d   = bus.redirect_pc & ~XLEN'(3);
      count_d    = '0;
      outst_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
      drop_d     = outst_q + drop_q + CW'(req_fire) - CW'(rsp_ok);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        outst_d    = outst_d + CW'(1);
      end
      if (rsp_ok) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          wr_en    = 1'b1;
          wr_d     = wr_q + PW'(1);
          rsp_pc_d = rsp_pc_q + XLEN'(4);
          outst_d  = outst_d - CW'(1);
          count_d  = count_d + CW'(1);
        end
      end
      if (out_fire) begin
        rd_d    = rd_q + PW'(1);
        count_d = count_d - CW'(1);
      end
    end

    credit_ok = (count_d + outst_d + drop_d) < CW'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      count_q       <= '0;
      outst_q       <= '0;
      drop_q        <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      count_q       <= count_d;
      outst_q       <= outst_d;
      drop_q        <= drop_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      req_valid_q   <= credit_ok;
      instr_valid_q <= (count_d != '0);
      if (wr_en) begin
        entries_q[wr_q] <= '{pc: rsp_pc_q, word: bus.imem_rsp_data};
      end
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.instr_valid    = instr_valid_q;
  assign bus.instr          = entries_q[rd_q].word;
  assign bus.instr_pc       = entries_q[rd_q].pc;
  assign bus.op             = entries_q[rd_q].word[6:0];
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Scoreboard bench for instr_prefetch_buffer: behavioural memory with variable
// latency, PC-stream reference model, directed scenarios plus random traffic.
module tb_instr_prefetch_buffer;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mrsp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  instr_prefetch_buffer_if #(.XLEN(XLEN)) bus ();

  instr_prefetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          last_due = 0;
  int          n_req    = 0;
  int          n_out    = 0;
  logic [31:0] mpc      = RESET_PC;
  logic [31:0] sb [$];
  mrsp_t       memq [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, want, cyc);
  endtask

  // One clock cycle: drive inputs, play memory, track expected PC stream
  task automatic do_cycle(input bit rst, input bit rdy, input bit rq_rdy,
                          input bit redir, input logic [31:0] rpc);
    bit popped;
    int due;
    @(posedge clk);
    #1;
    cyc++;
    reset              = rst;
    bus.instr_ready    = rdy;
    bus.imem_req_ready = rq_rdy && !rst;
    bus.redirect_valid = redir && !rst;
    bus.redirect_pc    = rpc;
    popped             = 1'b0;
    if (rst) begin
      memq.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      mpc                = RESET_PC;
      last_due           = cyc;
    end else begin
      if (memq.size() != 0 && memq[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = memq[0].data;
        void'(memq.pop_front());
        popped = 1'b1;
      end else begin
        bus.imem_rsp_valid = 1'b0;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("imem_addr", bus.imem_addr, mpc);
        due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        memq.push_back('{data: mem_word(bus.imem_addr), due: due});
        last_due = due;
        n_req++;
        chk("credit", 32'((memq.size() + (popped ? 1 : 0)) <= int'(DEPTH)), 32'd1);
        if (!redir) sb.push_back(mpc);
        mpc = mpc + 32'd4;
      end
      if (redir) mpc = rpc & ~32'd3;
    end
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) do_cycle(1'b0, rdy, 1'b1, 1'b0, '0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"},   32'(bus.imem_req_valid), 32'd0);
    chk({tag, "_imem_addr"},   bus.imem_addr, RESET_PC);
    chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_instr"},       bus.instr, 32'd0);
    chk({tag, "_instr_pc"},    bus.instr_pc, 32'd0);
    chk({tag, "_op"},          32'(bus.op), 32'd0);
  endtask

  // Monitor: pops the expected PC on every consumed instruction
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
      end else begin
        if (bus.instr_valid && bus.instr_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow: instr_pc %h delivered, required nothing pending (cycle %0d)",
                     bus.instr_pc, cyc);
          end else begin
            e = sb.pop_front();
            chk("instr_pc", bus.instr_pc, e);
            chk("instr",    bus.instr, mem_word(e));
            chk("op",       32'(bus.op), 32'(mem_word(e) & 32'h7f));
            n_out++;
          end
        end
        if (bus.redirect_valid) sb.delete();
      end
    end
  end

  initial begin
    bit          rdy, rq, rd, rs;
    logic [31:0] rpc;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;

    // Reset values and startup latency
    do_reset(3);
    chk_reset_outputs("rst");
    lat = 1;
    run(1, 1'b1);
    chk("c0_req_valid", 32'(bus.imem_req_valid), 32'd0);
    run(1, 1'b1);
    chk("c1_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("c1_addr", bus.imem_addr, 32'd0);
    run(1, 1'b1);
    chk("c2_instr_valid", 32'(bus.instr_valid), 32'd0);
    run(1, 1'b1);
    chk("c3_instr_valid", 32'(bus.instr_valid), 32'd1);
    chk("c3_instr_pc", bus.instr_pc, 32'd0);
    run(20, 1'b1);

    // Decoder stall: credit limits to DEPTH requests
    do_reset(2);
    n_req = 0;
    run(12, 1'b0);
    chk("stall_nreq", 32'(n_req), 32'(DEPTH));
    chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("stall_instr_valid", 32'(bus.instr_valid), 32'd1);
    run(20, 1'b1);

    // Redirect with two requests in flight at latency 3
    do_reset(2);
    lat = 3;
    run(3, 1'b1);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    run(1, 1'b1);
    chk("redir_instr_valid", 32'(bus.instr_valid), 32'd0);
    run(20, 1'b1);

    // Redirect coinciding with response and consume; misaligned target
    do_reset(2);
    lat = 1;
    run(3, 1'b1);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h203);
    chk("same_cyc_instr_valid", 32'(bus.instr_valid), 32'd1);
    run(1, 1'b1);
    chk("same_cyc_after_valid", 32'(bus.instr_valid), 32'd0);
    run(15, 1'b1);

    // Reset with buffer full
    run(8, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    run(1, 1'b1);
    chk_reset_outputs("midrst");
    run(15, 1'b1);

    // Address wrap
    do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    run(12, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) lat = int'($urandom_range(1, 3));
      rdy = ($urandom_range(0, 3) != 0);
      rq  = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      rs  = ($urandom_range(0, 249) == 0);
      rpc = $urandom();
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      do_cycle(rs, rdy, rq, rd, rpc);
    end
    run(20, 1'b1);
    chk("progress", 32'(n_out > 500), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
